// File: rtl/multi_ch_sample_queue.sv
// Circular multi-channel sample queue: stores every written frame and, once RD_LEN frames
// are held, replays the RD_LEN most recent frames oldest-first as a framed burst.
module multi_ch_sample_queue #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1536,
  parameter int RD_LEN = 1021
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wrt_smpl,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  output logic [NUM_CH*DATA_W-1:0] smpl_out,
  output logic                     smpl_vld,
  output logic                     smpl_first,
  output logic                     smpl_last,
  output logic                     sequencing,
  output logic                     full,
  output logic                     overrun
);

  localparam int FW    = NUM_CH * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LEN + 1);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t           state;
  logic [FW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] new_ptr, old_ptr, rd_ptr, old_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, seq_cnt;
  logic             last_addr;
  logic             wr_en;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (cnt == CNT_W'(RD_LEN));
  assign sequencing = (state == SEQ);
  assign last_addr  = (seq_cnt == CNT_W'(RD_LEN - 1));
  // A frame presented together with reset or clear is dropped along with the queue contents.
  assign wr_en      = wrt_smpl && rst_n && !clr;

  always_comb begin
    cnt_nxt = cnt;
    old_nxt = old_ptr;
    if (wrt_smpl) begin
      if (full) old_nxt = inc(old_ptr);
      else      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[new_ptr] <= smpl_in;
    smpl_out <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state      <= IDLE;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      seq_cnt    <= '0;
      smpl_vld   <= 1'b0;
      smpl_first <= 1'b0;
      smpl_last  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wrt_smpl) begin
        new_ptr <= inc(new_ptr);
        old_ptr <= old_nxt;
        cnt     <= cnt_nxt;
      end
      overrun    <= wrt_smpl && (state == SEQ);
      smpl_vld   <= (state == SEQ);
      smpl_first <= (state == SEQ) && (seq_cnt == '0);
      smpl_last  <= (state == SEQ) && last_addr;
      case (state)
        IDLE: begin
          if (wrt_smpl && cnt_nxt == CNT_W'(RD_LEN)) begin
            state   <= SEQ;
            rd_ptr  <= old_nxt;
            seq_cnt <= '0;
          end
        end
        SEQ: begin
          rd_ptr  <= inc(rd_ptr);
          seq_cnt <= seq_cnt + 1'b1;
          if (last_addr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ch_sample_queue.sv
// Bench for multi_ch_sample_queue: small instance checked every cycle against a queue-based
// model, plus a default-parameter instance checked with literal burst expectations.
module tb_multi_ch_sample_queue;

  localparam int RL  = 5;
  localparam int BRL = 1021;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wrt = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] s_out;
  logic        s_vld, s_first, s_last, s_seq, s_full, s_ovr;

  logic        clr_b = 1'b0;
  logic        wrt_b = 1'b0;
  logic [31:0] din_b = '0;
  logic [31:0] b_out;
  logic        b_vld, b_first, b_last, b_seq, b_full, b_ovr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_ch_sample_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(8), .RD_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_smpl(wrt), .smpl_in(din),
    .smpl_out(s_out), .smpl_vld(s_vld), .smpl_first(s_first), .smpl_last(s_last),
    .sequencing(s_seq), .full(s_full), .overrun(s_ovr)
  );

  multi_ch_sample_queue dut_big (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .wrt_smpl(wrt_b), .smpl_in(din_b),
    .smpl_out(b_out), .smpl_vld(b_vld), .smpl_first(b_first), .smpl_last(b_last),
    .sequencing(b_seq), .full(b_full), .overrun(b_ovr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: history of the last RL frames since clear; a burst is the window captured at its
  // start edge, returned on the RL cycles after that edge.
  int unsigned edge_n = 0;
  int unsigned s_edge = 0;
  logic [31:0] hist[$];
  logic [31:0] win[RL];
  bit          act = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_live = 1'b0;
  bit          busy;

  always @(posedge clk) begin
    edge_n++;
    m_ovr = 1'b0;
    if (!rst_n || clr) begin
      hist.delete();
      act = 1'b0;
      m_live = 1'b1;
    end else if (wrt) begin
      busy = act && (edge_n - s_edge >= 1) && (edge_n - s_edge <= RL);
      hist.push_back(din);
      if (hist.size() > RL) void'(hist.pop_front());
      if (busy) m_ovr = 1'b1;
      else if (hist.size() == RL) begin
        act = 1'b1;
        s_edge = edge_n;
        for (int i = 0; i < RL; i++) win[i] = hist[i];
      end
    end
  end

  logic [15:0] cap[$];
  int ovr_seen = 0;
  int firsts = 0;
  int lasts = 0;

  always @(negedge clk) begin
    if (m_live) begin
      int unsigned d;
      bit e_seq, e_vld;
      d = edge_n - s_edge;
      e_seq = act && (d <= RL - 1);
      e_vld = act && (d >= 1) && (d <= RL);
      chk("sequencing", s_seq, e_seq);
      chk("full", s_full, hist.size() == RL);
      chk("smpl_vld", s_vld, e_vld);
      chk("smpl_first", s_first, e_vld && d == 1);
      chk("smpl_last", s_last, e_vld && d == RL);
      chk("overrun", s_ovr, m_ovr);
      if (e_vld) chk("smpl_out", s_out, win[d-1]);
      if (s_vld) cap.push_back(s_out[15:0]);
      if (s_ovr) ovr_seen++;
      if (s_vld && s_first) firsts++;
      if (s_vld && s_last) lasts++;
    end
  end

  int          bcnt = 0, bfirsts = 0, blasts = 0, bmono = 0;
  logic [31:0] bfirst_val = '0, blast_val = '0;
  logic [15:0] bprev = '0;

  always @(negedge clk) begin
    if (b_vld) begin
      bcnt++;
      if (b_first) begin bfirsts++; bfirst_val = b_out; end
      if (b_last)  begin blasts++;  blast_val  = b_out; end
      if (!b_first && b_out[15:0] != bprev + 16'd1) bmono++;
      if (b_out[31:16] != b_out[15:0] + 16'd100) bmono++;
      bprev = b_out[15:0];
    end
  end

  function automatic logic [31:0] frame(input int k);
    return {16'(k + 100), 16'(k)};
  endfunction

  task automatic wr(input int k);
    @(negedge clk);
    wrt = 1'b1;
    din = frame(k);
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_cap(input string name, input int base, input int n);
    chk({name, " len"}, cap.size(), n);
    for (int i = 0; i < n; i++)
      if (i < cap.size()) chk(name, cap[i], 16'(base + i));
    cap.delete();
  endtask

  task automatic scenario1(input string tag);
    cap.delete();
    firsts = 0;
    lasts = 0;
    for (int k = 1; k <= 4; k++) begin
      wr(k);
      idle(9);
    end
    chk({tag, " no early burst"}, cap.size(), 0);
    chk({tag, " not full at 4"}, s_full, 1'b0);
    wr(5);
    idle(10);
    chk({tag, " full at 5"}, s_full, 1'b1);
    check_cap({tag, " burst"}, 1, 5);
    chk({tag, " first count"}, firsts, 1);
    chk({tag, " last count"}, lasts, 1);
  endtask

  initial begin
    idle(2);
    rst_n = 1'b1;
    chk("reset full", s_full, 1'b0);
    chk("reset vld", s_vld, 1'b0);
    chk("reset seq", s_seq, 1'b0);
    chk("reset ovr", s_ovr, 1'b0);

    scenario1("s1");

    for (int k = 6; k <= 11; k++) begin
      wr(k);
      idle(10);
    end
    cap.delete();
    wr(12);
    idle(10);
    check_cap("s2 wrap", 8, 5);

    pulse_clr();
    for (int k = 1; k <= 5; k++) begin
      wr(k);
      idle(10);
    end
    cap.delete();
    ovr_seen = 0;
    wr(6);
    wr(7);
    idle(10);
    check_cap("s3 burst", 2, 5);
    chk("s3 overrun count", ovr_seen, 1);
    wr(8);
    idle(10);
    check_cap("s3 after", 4, 5);

    pulse_clr();
    for (int k = 1; k <= 4; k++) begin
      wr(k);
      idle(10);
    end
    cap.delete();
    wr(5);
    idle(1);
    pulse_clr();
    chk("s4 full after clr", s_full, 1'b0);
    chk("s4 vld after clr", s_vld, 1'b0);
    idle(8);
    chk("s4 aborted len", cap.size(), 2);
    scenario1("s4");

    wr(6);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("s5 full", s_full, 1'b0);
    chk("s5 vld", s_vld, 1'b0);
    chk("s5 seq", s_seq, 1'b0);
    chk("s5 first", s_first, 1'b0);
    chk("s5 last", s_last, 1'b0);
    idle(8);
    scenario1("s5");

    for (int it = 0; it < 400; it++) begin
      int unsigned gap;
      gap = $urandom_range(0, 7);
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b1;
        wrt = 1'b0;
      end else begin
        wrt = 1'b1;
        din = $urandom;
      end
      @(negedge clk);
      clr = 1'b0;
      wrt = 1'b0;
      idle(gap);
    end
    idle(10);

    for (int k = 1; k <= BRL; k++) begin
      @(negedge clk);
      wrt_b = 1'b1;
      din_b = frame(k);
    end
    @(negedge clk);
    wrt_b = 1'b0;
    begin
      int n;
      n = 0;
      while ((b_seq || b_vld) && n < 1100) begin
        @(negedge clk);
        n++;
      end
      chk("s6 ramp burst timeout", n < 1100, 1'b1);
    end
    chk("s6 full", b_full, 1'b1);
    bcnt = 0;
    bfirsts = 0;
    blasts = 0;
    bmono = 0;
    @(negedge clk);
    wrt_b = 1'b1;
    din_b = frame(BRL + 1);
    @(negedge clk);
    wrt_b = 1'b0;
    begin
      int n;
      n = 0;
      while (blasts == 0 && n < 1100) begin
        @(negedge clk);
        n++;
      end
      chk("s6 burst timeout", n < 1100, 1'b1);
    end
    idle(3);
    chk("s6 vld count", bcnt, BRL);
    chk("s6 first count", bfirsts, 1);
    chk("s6 last count", blasts, 1);
    chk("s6 oldest", bfirst_val, frame(2));
    chk("s6 newest", blast_val, frame(BRL + 1));
    chk("s6 sequence errors", bmono, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
